risc_16bit: RTL and testbench

//   Single-cycle 16-bit load/store RISC core: 8 GPRs, unified 256x16 instruction/data memory.

---
 rtl/risc_16bit.sv | 149 ++++++++++++++
 tb/tb_risc_16bit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/risc_16bit.sv
// rtl/risc_16bit.sv - single-cycle 16-bit load/store RISC core with unified 256x16 memory
// Fetch/decode are combinational from memory[PC]; all architectural state updates on one edge.
module risc_16bit #(
  parameter int MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] ALU_OUT,
  output logic [15:0] MAX_VAL
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [4:0] OP_ADD   = 5'b00000;
  localparam logic [4:0] OP_SUB   = 5'b00001;
  localparam logic [4:0] OP_MUL   = 5'b00010;
  localparam logic [4:0] OP_AND   = 5'b00011;
  localparam logic [4:0] OP_OR    = 5'b00100;
  localparam logic [4:0] OP_INV   = 5'b00101;
  localparam logic [4:0] OP_LSL   = 5'b00110;
  localparam logic [4:0] OP_LSR   = 5'b00111;
  localparam logic [4:0] OP_DEC   = 5'b01000;
  localparam logic [4:0] OP_INC   = 5'b01001;
  localparam logic [4:0] OP_MOV   = 5'b01010;
  localparam logic [4:0] OP_SLT   = 5'b01011;
  localparam logic [4:0] OP_ADDI  = 5'b01100;
  localparam logic [4:0] OP_SUBI  = 5'b01101;
  localparam logic [4:0] OP_SLTI  = 5'b01110;
  localparam logic [4:0] OP_MOVI  = 5'b01111;
  localparam logic [4:0] OP_BNEQ  = 5'b10000;
  localparam logic [4:0] OP_BEQ   = 5'b10001;
  localparam logic [4:0] OP_BEQZ  = 5'b10010;
  localparam logic [4:0] OP_BNEQZ = 5'b10011;
  localparam logic [4:0] OP_LD    = 5'b10100;
  localparam logic [4:0] OP_ST    = 5'b10101;
  localparam logic [4:0] OP_HALT  = 5'b10110;

  logic [15:0] memory   [0:MEM_DEPTH-1];
  logic [15:0] reg_bank [0:7];
  logic [15:0] PC;
  logic        halted;

  logic [15:0]   w_instr;
  logic [4:0]    w_opcode;
  logic [2:0]    w_rs1_idx;
  logic [2:0]    w_rs2_idx;
  logic [2:0]    w_rd_r;
  logic [15:0]   w_imm;
  logic [15:0]   w_a;
  logic [15:0]   w_b;
  logic [15:0]   w_eff_addr;
  logic [AW-1:0] w_mem_idx;

  logic [15:0] w_result;
  logic [2:0]  w_wr_idx;
  logic        w_wr_en;
  logic        w_alu_en;
  logic [15:0] w_alu_val;
  logic [15:0] w_next_pc;
  logic        w_mem_we;
  logic        w_halt;

  assign w_instr    = memory[PC[AW-1:0]];
  assign w_opcode   = w_instr[15:11];
  assign w_rs1_idx  = w_instr[10:8];
  assign w_rs2_idx  = w_instr[7:5];
  assign w_rd_r     = w_instr[4:2];
  assign w_imm      = {{11{w_instr[4]}}, w_instr[4:0]};
  assign w_a        = reg_bank[w_rs1_idx];
  assign w_b        = reg_bank[w_rs2_idx];
  // [7:5] doubles as the base register for LD/ST, so the address path reuses w_b
  assign w_eff_addr = w_b + w_imm;
  assign w_mem_idx  = w_eff_addr[AW-1:0];
  assign MAX_VAL    = reg_bank[2];

  always_comb begin
    w_result  = '0;
    w_wr_idx  = w_rd_r;
    w_wr_en   = 1'b0;
    w_alu_en  = 1'b0;
    w_alu_val = '0;
    w_next_pc = PC + 16'd1;
    w_mem_we  = 1'b0;
    w_halt    = 1'b0;

    case (w_opcode)
      OP_ADD:  begin w_result = w_a + w_b;               w_wr_en = 1'b1; end
      OP_SUB:  begin w_result = w_a - w_b;               w_wr_en = 1'b1; end
      OP_MUL:  begin w_result = w_a * w_b;               w_wr_en = 1'b1; end
      OP_AND:  begin w_result = w_a & w_b;               w_wr_en = 1'b1; end
      OP_OR:   begin w_result = w_a | w_b;               w_wr_en = 1'b1; end
      OP_INV:  begin w_result = ~w_a;                    w_wr_en = 1'b1; end
      OP_LSL:  begin w_result = w_a << w_b[3:0];         w_wr_en = 1'b1; end
      OP_LSR:  begin w_result = w_a >> w_b[3:0];         w_wr_en = 1'b1; end
      OP_DEC:  begin w_result = w_a - 16'd1;             w_wr_en = 1'b1; end
      OP_INC:  begin w_result = w_a + 16'd1;             w_wr_en = 1'b1; end
      OP_MOV:  begin w_result = w_a;                     w_wr_en = 1'b1; end
      OP_SLT:  begin w_result = {15'd0, (w_a < w_b)};    w_wr_en = 1'b1; end
      OP_ADDI: begin w_result = w_a + w_imm;   w_wr_idx = w_rs2_idx; w_wr_en = 1'b1; end
      OP_SUBI: begin w_result = w_a - w_imm;   w_wr_idx = w_rs2_idx; w_wr_en = 1'b1; end
      OP_SLTI: begin w_result = {15'd0, (w_a < w_imm)}; w_wr_idx = w_rs2_idx; w_wr_en = 1'b1; end
      OP_MOVI: begin w_result = w_imm;         w_wr_idx = w_rs2_idx; w_wr_en = 1'b1; end
      OP_BNEQ:  if (w_a != w_b)   w_next_pc = PC + w_imm;
      OP_BEQ:   if (w_a == w_b)   w_next_pc = PC + w_imm;
      OP_BEQZ:  if (w_a == 16'd0) w_next_pc = PC + w_imm;
      OP_BNEQZ: if (w_a != 16'd0) w_next_pc = PC + w_imm;
      OP_LD: begin
        w_result = memory[w_mem_idx];
        w_wr_idx = w_rs1_idx;
        w_wr_en  = 1'b1;
      end
      OP_ST: begin
        w_mem_we  = 1'b1;
        w_alu_en  = 1'b1;
        w_alu_val = w_eff_addr;
      end
      OP_HALT: begin
        w_halt    = 1'b1;
        w_next_pc = PC;
      end
      default: ;
    endcase

    if (w_wr_en) begin
      w_alu_en  = 1'b1;
      w_alu_val = w_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC      <= '0;
      halted  <= 1'b0;
      ALU_OUT <= '0;
      for (int i = 0; i < 8; i++) reg_bank[i] <= '0;
    end else if (!halted) begin
      PC <= w_next_pc;
      if (w_halt)   halted <= 1'b1;
      if (w_wr_en)  reg_bank[w_wr_idx] <= w_result;
      if (w_alu_en) ALU_OUT <= w_alu_val;
    end
  end

  // Memory has no reset so preloaded programs survive; stores are blocked while in reset
  always_ff @(posedge clk) begin
    if (rst_n && !halted && w_mem_we) memory[w_mem_idx] <= w_a;
  end

endmodule

// File: tb/tb_risc_16bit.sv
// tb/tb_risc_16bit.sv - directed self-checking bench for risc_16bit
module tb_risc_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] alu_out;
  logic [15:0] max_val;

  int checks   = 0;
  int failures = 0;

  logic [15:0] alu_prog [0:23];
  int          alu_reg  [0:22];
  logic [15:0] alu_val  [0:22];
  logic [15:0] br_pc    [0:9];

  risc_16bit #(.MEM_DEPTH(256)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ALU_OUT (alu_out),
    .MAX_VAL (max_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rt(input logic [4:0] op, input logic [2:0] s1,
                                     input logic [2:0] s2, input logic [2:0] d);
    return {op, s1, s2, d, 2'b00};
  endfunction

  function automatic logic [15:0] it(input logic [4:0] op, input logic [2:0] a,
                                     input logic [2:0] b, input logic [4:0] imm);
    return {op, a, b, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_mem();
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) dut.memory[i] = 16'hF800;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input string tag, input int budget);
    int n;
    n = 0;
    while (!dut.halted && n < budget) begin
      step();
      n++;
    end
    check(tag, {31'd0, dut.halted}, 32'd1);
  endtask

  task automatic load_max();
    clear_mem();
    dut.memory[0] = it(5'b01111, 3'd0, 3'd4, 5'd8);
    dut.memory[1] = it(5'b01111, 3'd0, 3'd0, 5'd0);
    dut.memory[2] = it(5'b10100, 3'd1, 3'd4, 5'd15);
    dut.memory[3] = rt(5'b01011, 3'd2, 3'd1, 3'd0);
    dut.memory[4] = rt(5'b01000, 3'd4, 3'd0, 3'd4);
    dut.memory[5] = it(5'b10010, 3'd0, 3'd0, 5'd2);
    dut.memory[6] = rt(5'b01010, 3'd1, 3'd0, 3'd2);
    dut.memory[7] = it(5'b10011, 3'd4, 3'd0, 5'b11010);
    dut.memory[8] = 16'hB000;
    dut.memory[16] = 16'd0;   dut.memory[17] = 16'd121;
    dut.memory[18] = 16'd14;  dut.memory[19] = 16'd9;
    dut.memory[20] = 16'd123; dut.memory[21] = 16'd231;
    dut.memory[22] = 16'd78;  dut.memory[23] = 16'd94;
  endtask

  task automatic set_alu(input int k, input logic [15:0] w, input int r, input logic [15:0] v);
    alu_prog[k] = w;
    alu_reg[k]  = r;
    alu_val[k]  = v;
  endtask

  initial begin
    rst_n = 1'b0;

    // Reset state
    clear_mem();
    #1;
    check("rst_pc",     {16'd0, dut.PC}, 32'd0);
    check("rst_alu",    {16'd0, alu_out}, 32'd0);
    check("rst_halted", {31'd0, dut.halted}, 32'd0);
    check("rst_r5",     {16'd0, dut.reg_bank[5]}, 32'd0);

    // ALU program: each step checks the destination register, ALU_OUT and PC
    set_alu(0,  it(5'b01111, 3'd0, 3'd2, 5'd5),  2, 16'd5);
    set_alu(1,  it(5'b01111, 3'd0, 3'd3, 5'd3),  3, 16'd3);
    set_alu(2,  rt(5'b00000, 3'd3, 3'd2, 3'd1),  1, 16'd8);
    set_alu(3,  rt(5'b00001, 3'd3, 3'd2, 3'd1),  1, 16'hFFFE);
    set_alu(4,  rt(5'b00010, 3'd3, 3'd2, 3'd1),  1, 16'd15);
    set_alu(5,  rt(5'b00011, 3'd3, 3'd2, 3'd1),  1, 16'd1);
    set_alu(6,  rt(5'b00100, 3'd3, 3'd2, 3'd1),  1, 16'd7);
    set_alu(7,  rt(5'b00110, 3'd3, 3'd2, 3'd1),  1, 16'd96);
    set_alu(8,  rt(5'b00111, 3'd3, 3'd2, 3'd1),  1, 16'd0);
    set_alu(9,  it(5'b01100, 3'd2, 3'd1, 5'd7),  1, 16'd12);
    set_alu(10, it(5'b01110, 3'd2, 3'd1, 5'd7),  1, 16'd1);
    set_alu(11, it(5'b01111, 3'd0, 3'd1, 5'd7),  1, 16'd7);
    set_alu(12, it(5'b01111, 3'd0, 3'd5, 5'b11111), 5, 16'hFFFF);
    set_alu(13, rt(5'b01001, 3'd5, 3'd0, 3'd1),  1, 16'd0);
    set_alu(14, it(5'b01111, 3'd0, 3'd6, 5'd1),  6, 16'd1);
    set_alu(15, it(5'b01111, 3'd0, 3'd7, 5'd8),  7, 16'd8);
    set_alu(16, rt(5'b00110, 3'd6, 3'd7, 3'd6),  6, 16'h0100);
    set_alu(17, rt(5'b00010, 3'd6, 3'd6, 3'd1),  1, 16'd0);
    set_alu(18, it(5'b01111, 3'd0, 3'd1, 5'd9),  1, 16'd9);
    set_alu(19, 16'hF800,                        1, 16'd9);
    set_alu(20, rt(5'b01000, 3'd1, 3'd0, 3'd1),  1, 16'd8);
    set_alu(21, rt(5'b01011, 3'd3, 3'd2, 3'd1),  1, 16'd1);
    set_alu(22, rt(5'b00101, 3'd3, 3'd0, 3'd1),  1, 16'hFFFC);
    alu_prog[23] = 16'hB000;
    for (int k = 0; k < 24; k++) dut.memory[k] = alu_prog[k];
    release_reset();
    for (int k = 0; k < 23; k++) begin
      step();
      check($sformatf("alu%0d_reg", k), {16'd0, dut.reg_bank[alu_reg[k]]}, {16'd0, alu_val[k]});
      check($sformatf("alu%0d_out", k), {16'd0, alu_out}, {16'd0, alu_val[k]});
      check($sformatf("alu%0d_pc", k),  {16'd0, dut.PC}, k + 1);
    end
    step();
    check("alu_halted", {31'd0, dut.halted}, 32'd1);
    for (int k = 0; k < 3; k++) step();
    check("alu_halt_pc",  {16'd0, dut.PC}, 32'd23);
    check("alu_halt_out", {16'd0, alu_out}, 32'hFFFC);

    // Load/store
    clear_mem();
    dut.memory[21] = 16'd99;
    dut.memory[0] = it(5'b01111, 3'd0, 3'd6, 5'd6);
    dut.memory[1] = it(5'b10100, 3'd1, 3'd6, 5'd15);
    dut.memory[2] = it(5'b01111, 3'd0, 3'd7, 5'd7);
    dut.memory[3] = it(5'b10101, 3'd1, 3'd7, 5'd15);
    dut.memory[4] = 16'hB000;
    release_reset();
    step(); step();
    check("ld_r1",  {16'd0, dut.reg_bank[1]}, 32'd99);
    check("ld_out", {16'd0, alu_out}, 32'd99);
    step(); step();
    check("st_mem", {16'd0, dut.memory[22]}, 32'd99);
    check("st_out", {16'd0, alu_out}, 32'd22);
    run_to_halt("ls_halt", 20);

    // Branches: PC after each executed instruction
    clear_mem();
    dut.memory[0]  = it(5'b01111, 3'd0, 3'd5, 5'd3);
    dut.memory[1]  = it(5'b10010, 3'd0, 3'd0, 5'd5);
    dut.memory[2]  = it(5'b10011, 3'd6, 3'd0, 5'd3);
    dut.memory[3]  = it(5'b10000, 3'd5, 3'd5, 5'd3);
    dut.memory[4]  = it(5'b10001, 3'd0, 3'd0, 5'd4);
    dut.memory[6]  = it(5'b01111, 3'd0, 3'd0, 5'd1);
    dut.memory[7]  = it(5'b10011, 3'd5, 3'd0, 5'b11010);
    dut.memory[8]  = it(5'b10000, 3'd5, 3'd0, 5'd2);
    dut.memory[10] = 16'hB000;
    br_pc[0] = 16'd1; br_pc[1] = 16'd6; br_pc[2] = 16'd7; br_pc[3] = 16'd1;
    br_pc[4] = 16'd2; br_pc[5] = 16'd3; br_pc[6] = 16'd4; br_pc[7] = 16'd8;
    br_pc[8] = 16'd10; br_pc[9] = 16'd10;
    release_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("br%0d_pc", k), {16'd0, dut.PC}, {16'd0, br_pc[k]});
    end
    check("br_halted", {31'd0, dut.halted}, 32'd1);
    check("br_out",    {16'd0, alu_out}, 32'd1);

    // Max of array, with an asynchronous reset mid-run
    load_max();
    release_reset();
    for (int k = 0; k < 10; k++) step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pc",   {16'd0, dut.PC}, 32'd0);
    check("mid_rst_r4",   {16'd0, dut.reg_bank[4]}, 32'd0);
    check("mid_rst_max",  {16'd0, max_val}, 32'd0);
    check("mid_rst_out",  {16'd0, alu_out}, 32'd0);
    check("mid_rst_mem0", {16'd0, dut.memory[0]}, {16'd0, it(5'b01111, 3'd0, 3'd4, 5'd8)});
    check("mid_rst_mem21", {16'd0, dut.memory[21]}, 32'd231);
    release_reset();
    run_to_halt("max_halt", 200);
    check("max_val", {16'd0, max_val}, 32'd231);
    check("max_pc",  {16'd0, dut.PC}, 32'd8);
    for (int k = 0; k < 5; k++) step();
    check("max_hold_pc",  {16'd0, dut.PC}, 32'd8);
    check("max_hold_out", {16'd0, alu_out}, 32'd0);
    check("max_hold_r4",  {16'd0, dut.reg_bank[4]}, 32'd0);
    check("max_hold_val", {16'd0, max_val}, 32'd231);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
